// File: rtl/monexp_sched.sv
// Round-robin scheduler that shares one modular-exponentiation engine among NREQ
// requesters: grants, sizes the exponent, starts the engine and returns its result.
module monexp_sched #(
  parameter int unsigned BITLEN     = 256,
  parameter int unsigned LOG_BITLEN = 8,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned TMO_BITS   = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*BITLEN-1:0]   req_e,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     err,
  output logic [BITLEN-1:0]        ans_out,
  output logic                     busy,
  output logic                     eng_start,
  output logic [BITLEN-1:0]        eng_e,
  output logic [LOG_BITLEN-1:0]    eng_e_idx,
  input  logic                     eng_stop,
  input  logic [BITLEN-1:0]        eng_ans
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TMO_BITS-1:0] TMO_LAST = {{(TMO_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_START, S_WAIT, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         ptr, win_idx;
  logic                  win_any;
  logic [NREQ-1:0]       win_oh, gnt_q;
  logic [BITLEN-1:0]     eng_e_q, ans_q;
  logic [LOG_BITLEN-1:0] idx_q, msb_idx;
  logic [TMO_BITS-1:0]   wdog;
  logic                  stop_prev, err_q, stop_rise, tmo_hit;

  // Search starts one past the last winner so a held request cannot starve others.
  always_comb begin
    int unsigned k;
    k       = 0;
    win_any = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      k = ({{(32-PW){1'b0}}, ptr} + i) % NREQ;
      if (!win_any && req[k]) begin
        win_any   = 1'b1;
        win_idx   = PW'(k);
        win_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    msb_idx = '0;
    for (int unsigned i = 0; i < BITLEN; i++) begin
      if (eng_e_q[i]) msb_idx = LOG_BITLEN'(i);
    end
  end

  // stop_prev tracks eng_stop in every state, so a level already high on WAIT entry is no edge.
  assign stop_rise = eng_stop & ~stop_prev;
  assign tmo_hit   = (wdog == TMO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_any) state_nxt = S_SCAN;
      S_SCAN:  state_nxt = (eng_e_q == '0) ? S_DONE : S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (stop_rise || tmo_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= PW'(NREQ - 1);
      gnt_q     <= '0;
      eng_e_q   <= '0;
      idx_q     <= '0;
      ans_q     <= '0;
      wdog      <= '0;
      stop_prev <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      stop_prev <= eng_stop;
      case (state)
        S_IDLE: begin
          if (win_any) begin
            gnt_q   <= win_oh;
            ptr     <= win_idx;
            eng_e_q <= req_e[int'(win_idx)*BITLEN +: BITLEN];
            err_q   <= 1'b0;
          end
        end
        S_SCAN: begin
          idx_q <= msb_idx;
          if (eng_e_q == '0) ans_q <= BITLEN'(1);
        end
        S_START: wdog <= '0;
        S_WAIT: begin
          wdog <= wdog + TMO_BITS'(1);
          if (stop_rise)    ans_q <= eng_ans;
          else if (tmo_hit) err_q <= 1'b1;
        end
        S_DONE: begin
          gnt_q <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = (state == S_DONE) ? gnt_q : '0;
  assign err       = (state == S_DONE) && err_q;
  assign busy      = (state != S_IDLE);
  assign eng_start = (state == S_START);
  assign eng_e     = eng_e_q;
  assign eng_e_idx = idx_q;
  assign ans_out   = ans_q;

endmodule

// File: tb/tb_monexp_sched.sv
// Bench for monexp_sched: job vectors from a table, results checked through a
// done-driven scoreboard, plus round-robin, timeout and async-reset sequences.
module tb_monexp_sched;
  localparam int unsigned BL = 32, LB = 5, NR = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*BL-1:0]  req_e = '0;
  logic              eng_stop = 1'b0;
  logic [BL-1:0]     eng_ans = '0;

  logic [NR-1:0] a_gnt, a_done, b_gnt, b_done;
  logic          a_err, a_busy, a_eng_start, b_err, b_busy, b_eng_start;
  logic [BL-1:0] a_ans_out, a_eng_e, b_ans_out, b_eng_e;
  logic [LB-1:0] a_eng_e_idx, b_eng_e_idx;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          who;
    logic [31:0] e;
    int          lat;
    logic [31:0] eans;
    logic [4:0]  xidx;
    logic [31:0] xans;
    bit          drop;
  } vec_t;

  typedef struct {
    logic [3:0]  done;
    logic [31:0] ans;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];

  always #5 clk = ~clk;

  monexp_sched #(.BITLEN(BL), .LOG_BITLEN(LB), .NREQ(NR), .TMO_BITS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .req_e(req_e), .gnt(a_gnt), .done(a_done),
    .err(a_err), .ans_out(a_ans_out), .busy(a_busy), .eng_start(a_eng_start),
    .eng_e(a_eng_e), .eng_e_idx(a_eng_e_idx), .eng_stop(eng_stop), .eng_ans(eng_ans));

  monexp_sched #(.BITLEN(BL), .LOG_BITLEN(LB), .NREQ(NR), .TMO_BITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .req_e(req_e), .gnt(b_gnt), .done(b_done),
    .err(b_err), .ans_out(b_ans_out), .busy(b_busy), .eng_start(b_eng_start),
    .eng_e(b_eng_e), .eng_e_idx(b_eng_e_idx), .eng_stop(eng_stop), .eng_ans(eng_ans));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && a_done != '0) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_done: got done=%b expected no done", a_done);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("sb_done", a_done, x.done);
        check("sb_ans", a_ans_out, x.ans);
        check("sb_err", a_err, x.err);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, a_gnt, 0);
    check({tag, "_done"}, a_done, 0);
    check({tag, "_err"}, a_err, 0);
    check({tag, "_start"}, a_eng_start, 0);
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_ans"}, a_ans_out, 0);
    check({tag, "_eng_e"}, a_eng_e, 0);
    check({tag, "_idx"}, a_eng_e_idx, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; req_e = '0; eng_stop = 1'b0; eng_ans = '0;
    #1 check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = (a_done != '0);
    end
    check(name, got, 1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] m;
    m = 4'b0001 << v.who;
    req_e[v.who*BL +: BL] = v.e;
    req = m;
    sb.push_back('{m, v.xans, 1'b0});
    @(negedge clk);
    check("grant", a_gnt, m);
    check("eng_e", a_eng_e, v.e);
    check("start_early", a_eng_start, 0);
    @(negedge clk);
    if (v.e != 0) begin
      check("start_n2", a_eng_start, 1);
      check("msb_idx", a_eng_e_idx, v.xidx);
      if (v.drop) req = '0;
      repeat (v.lat) @(negedge clk);
      eng_ans = v.eans;
      eng_stop = 1'b1;
      wait_done("done_seen", 20);
      eng_stop = 1'b0;
    end else begin
      check("no_start", a_eng_start, 0);
      check("zero_done_n2", a_done, m);
      check("idx_zero", a_eng_e_idx, 0);
    end
    req = '0;
    @(negedge clk);
    check("idle_after", a_busy, 0);
  endtask

  initial begin
    int rr_exp[5];
    vec_t zv;
    bit got;

    vecs[0] = '{0, 32'h0001_0001, 50, 32'h0000_0ABC, 5'd16, 32'h0000_0ABC, 1'b0};
    vecs[1] = '{2, 32'h0000_0000,  0, 32'h0000_0000, 5'd0,  32'h0000_0001, 1'b0};
    vecs[2] = '{1, 32'h0000_0001,  3, 32'h0000_1234, 5'd0,  32'h0000_1234, 1'b0};
    vecs[3] = '{3, 32'h8000_0000,  5, 32'hDEAD_BEEF, 5'd31, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{0, 32'h0000_00F0,  1, 32'h0000_0055, 5'd7,  32'h0000_0055, 1'b1};
    rr_exp = '{0, 1, 2, 3, 0};

    do_reset();
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Round robin with all four requesters held.
    do_reset();
    for (int i = 0; i < NR; i++) req_e[i*BL +: BL] = 32'h3 << i;
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        got = a_eng_start;
      end
      check("rr_start_seen", got, 1);
      check("rr_grant", a_gnt, 4'b0001 << rr_exp[k]);
      sb.push_back('{4'b0001 << rr_exp[k], 32'h100 + k, 1'b0});
      repeat (2) @(negedge clk);
      eng_ans = 32'h100 + k;
      eng_stop = 1'b1;
      wait_done("rr_done_seen", 20);
      eng_stop = 1'b0;
      if (k == 4) req = '0;
    end
    @(negedge clk);

    // Stale eng_stop and watchdog timeout on the TMO_BITS=4 instance.
    do_reset();
    zv = '{0, 32'h0, 0, 32'h0, 5'd0, 32'h1, 1'b0};
    run_vec(zv);
    check("b_ans_before", b_ans_out, 1);
    eng_stop = 1'b1;
    req_e[BL-1:0] = 32'h5;
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    check("b_start", b_eng_start, 1);
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      if (t == 15) check("b_tmo_early", b_done, 0);
    end
    check("b_tmo_done", b_done, 4'b0001);
    check("b_tmo_err", b_err, 1);
    check("b_tmo_ans", b_ans_out, 1);
    @(negedge clk);
    check("b_err_pulse", b_err, 0);
    check("b_done_pulse", b_done, 0);

    // Async reset while dut_a is still waiting on the stale engine.
    check("a_busy_wait", a_busy, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    @(negedge clk);
    rst_n = 1'b1;
    eng_stop = 1'b0;
    req = '0;
    run_vec('{1, 32'h3, 4, 32'h77, 5'd1, 32'h77, 1'b0});

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
